microseq_ctrl_store: RTL and testbench
======================================

Name: microseq_ctrl_store

Overview:
- Parametrised, writable microprogram control store with an integrated microsequencer. Next generation of the fixed 256x64 combinational control ROM.
- Holds the microprogram in a loadable array. Computes the next micro-address each clock from sequencer fields in the current word. Registers the fetched word into a microinstruction register (MIR).
- Sits between the instruction-decode encoder (supplies the map address) and the datapath control lines.

Parameters:
- ADDR_W, 8, micro-address width; store depth = 2**ADDR_W.
- WORD_W, 64, microword width; must be at least 4+COND_SEL_W+ADDR_W+1.
- COND_SEL_W, 3, condition-select field width; cond input width = 2**COND_SEL_W.
- STACK_DEPTH, 4, microsubroutine return stack entries (>=1).

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- hold, input, 1, freezes the sequencer (uPC, MIR, stack) when 1.
- map_addr, input, ADDR_W, dispatch address from the instruction encoder.
- cond, input, 2**COND_SEL_W, status conditions (e.g. MOC, flags).
- ld_we, input, 1, control-store write enable.
- ld_addr, input, ADDR_W, write address.
- ld_data, input, WORD_W, write data.
- upc, output, ADDR_W, address of the word currently held in the MIR.
- ctrl_out, output, WORD_W-(4+COND_SEL_W+ADDR_W), control-field bits of the MIR.
- cond_taken, output, 1, (cond[S] ^ INV) for the current MIR.
- stack_ovf, output, 1, sticky overflow flag.
- stack_unf, output, 1, sticky underflow flag.

Behaviour:
- Microword layout, MSB down:
  - N[2:0]: sequencer operation.
  - INV: condition invert.
  - S[COND_SEL_W-1:0]: condition select.
  - CR[ADDR_W-1:0]: branch target.
  - Remaining low bits: ctrl_out.
- Store read is combinational from the array. The MIR is registered. ctrl_out, upc and cond_taken are functions of the MIR and uPC only.
- Reset is synchronous, takes priority over hold, and is honoured mid-operation. Reset values:
  - uPC = 0, MIR = 0, ctrl_out = 0, cond_taken = 0.
  - Stack pointer = 0, stack_ovf = 0, stack_unf = 0.
  - FSM enters BOOT.
  - Store contents are NOT cleared.
- FSM:
  - BOOT: next edge loads MIR = store[0] and uPC = 0, then goes to RUN. hold is ignored in BOOT.
  - RUN, hold=1: all state is unchanged.
  - RUN, hold=0: nxt is computed as below; uPC <= nxt and MIR <= store[nxt].
- Next-address computation, with t = cond[S]^INV and all increments modulo 2**ADDR_W:
  - 0 INCR: uPC+1.
  - 1 JUMP: CR.
  - 2 MAP: map_addr.
  - 3 CBR: t ? CR : uPC+1.
  - 4 CALL: push uPC+1, go to CR.
  - 5 RET: pop.
  - 6 WAIT: t ? uPC+1 : uPC. While stalled, the MIR is reloaded with the same word.
  - 7 RST: 0.
- Stack:
  - CALL when full: the push is dropped, the jump still occurs, stack_ovf is set.
  - RET when empty: nxt = 0 and stack_unf is set.
  - Both flags stay set until reset.
- Load port:
  - Write occurs on a clock edge when ld_we=1, regardless of hold or FSM state.
  - Same-edge write to the address being fetched: the MIR receives the old contents (read-before-write). The new contents are seen on the next fetch.

Optional Feature:
- Macro: MICROSEQ_STACK_EN.
- Defined: return stack, CALL/RET as above, ovf/unf flags live.
- Undefined:
  - No stack storage.
  - CALL behaves as JUMP, RET behaves as RST (nxt = 0).
  - stack_ovf and stack_unf are tied to 0.

Test Plan:
- Reset, then load store[0]=INCR, store[1]=JUMP CR=0x10. Release reset -> upc sequence 0, 1, 0x10; ctrl_out matches each word's low field; BOOT takes 1 cycle.
- CBR at 0x20 with S=2, INV=0, CR=0x40:
  - cond[2]=1 -> next upc 0x40.
  - cond[2]=0 -> next upc 0x21.
  - INV=1, cond[2]=0 -> next upc 0x40.
- WAIT at 0x05 on cond[0] (MOC): cond=0 for 3 cycles -> upc held at 0x05 for 3 cycles; cond=1 -> upc 0x06. Also: hold=1 for 2 cycles -> upc and ctrl_out frozen.
- Stack (MICROSEQ_STACK_EN defined, STACK_DEPTH=4):
  - 5 nested CALLs -> stack_ovf=1 after the 5th.
  - 4 RETs -> return addresses in LIFO order.
  - 5th RET -> upc 0, stack_unf=1.
- MAP at 0x03 with map_addr=0x80 -> next upc 0x80. INCR at 0xFF -> next upc 0x00 (wrap).
- ld_we to the address being fetched on the same edge -> MIR holds the old word; next fetch of that address returns the new word. Reset asserted mid-WAIT -> next cycle upc=0, ctrl_out=0, then BOOT fetch.

Source files
------------

// File: rtl/microseq_ctrl_store.sv
// microseq_ctrl_store: writable microprogram store with microsequencer and registered MIR.
// Define MICROSEQ_STACK_EN to enable the CALL/RET return stack and its overflow/underflow flags.
module microseq_ctrl_store #(
    parameter int ADDR_W      = 8,
    parameter int WORD_W      = 64,
    parameter int COND_SEL_W  = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    hold,
    input  logic [ADDR_W-1:0]                       map_addr,
    input  logic [2**COND_SEL_W-1:0]                cond,
    input  logic                                    ld_we,
    input  logic [ADDR_W-1:0]                       ld_addr,
    input  logic [WORD_W-1:0]                       ld_data,
    output logic [ADDR_W-1:0]                       upc,
    output logic [WORD_W-(4+COND_SEL_W+ADDR_W)-1:0] ctrl_out,
    output logic                                    cond_taken,
    output logic                                    stack_ovf,
    output logic                                    stack_unf
);
    localparam int CTRL_W = WORD_W - (4 + COND_SEL_W + ADDR_W);

    typedef enum logic {BOOT, RUN} state_t;
    state_t state_q, state_d;

    logic [WORD_W-1:0]     mem [2**ADDR_W];
    logic [WORD_W-1:0]     mir_q;
    logic [ADDR_W-1:0]     upc_q, upc_d, upc_inc, cr;
    logic [2:0]            op;
    logic [COND_SEL_W-1:0] sel;
    logic                  inv, t, adv;

    assign op         = mir_q[WORD_W-1 -: 3];
    assign inv        = mir_q[WORD_W-4];
    assign sel        = mir_q[WORD_W-5 -: COND_SEL_W];
    assign cr         = mir_q[CTRL_W +: ADDR_W];
    assign t          = cond[sel] ^ inv;
    assign upc_inc    = upc_q + 1'b1;
    assign adv        = state_q == RUN && !hold;
    assign upc        = upc_q;
    assign ctrl_out   = mir_q[CTRL_W-1:0];
    // MIR is zero while booting, so gate the condition to keep cond_taken low until RUN
    assign cond_taken = state_q == RUN && t;

`ifdef MICROSEQ_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
    logic              ovf_q, unf_q, full, empty, do_call, do_ret;

    assign full      = sp_q == SP_W'(STACK_DEPTH);
    assign empty     = sp_q == '0;
    assign sp_m1     = sp_q - 1'b1;
    assign do_call   = adv && op == 3'd4;
    assign do_ret    = adv && op == 3'd5;
    assign sp_d      = (do_call && !full) ? sp_q + 1'b1 : (do_ret && !empty) ? sp_m1 : sp_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_q | (do_call && full);
            unf_q <= unf_q | (do_ret && empty);
        end
    end

    always_ff @(posedge clk)
        if (!reset && do_call && !full) stk_q[sp_q[IDX_W-1:0]] <= upc_inc;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_comb begin
        upc_d = upc_inc;
        case (op)
            3'd1: upc_d = cr;
            3'd2: upc_d = map_addr;
            3'd3: upc_d = t ? cr : upc_inc;
`ifdef MICROSEQ_STACK_EN
            3'd4: upc_d = cr;
            3'd5: upc_d = empty ? '0 : stk_q[sp_m1[IDX_W-1:0]];
`else
            3'd4: upc_d = cr;
            3'd5: upc_d = '0;
`endif
            3'd6: upc_d = t ? upc_inc : upc_q;
            3'd7: upc_d = '0;
            default: upc_d = upc_inc;
        endcase
        if (state_q == BOOT) upc_d = '0;
    end

    always_comb state_d = (state_q == BOOT) ? RUN : state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            upc_q   <= '0;
            mir_q   <= '0;
        end else if (state_q == BOOT || adv) begin
            state_q <= state_d;
            upc_q   <= upc_d;
            mir_q   <= mem[upc_d];
        end
    end

    // Same-edge writes land after the fetch above samples the array (read-before-write)
    always_ff @(posedge clk)
        if (ld_we) mem[ld_addr] <= ld_data;
endmodule

// File: tb/tb_microseq_ctrl_store.sv
`timescale 1ns/1ps
module tb_microseq_ctrl_store;
    logic        clk = 1'b0, reset = 1'b1, hold = 1'b0, ld_we = 1'b0;
    logic [7:0]  map_addr = '0, ld_addr = '0, cond = '0, upc;
    logic [63:0] ld_data = '0;
    logic [48:0] ctrl_out;
    logic        cond_taken, stack_ovf, stack_unf;
    int          tests = 0, fails = 0;
    logic        chk_en = 1'b0;

    logic [63:0] m_mem [256];
    logic [7:0]  m_upc = '0;
    logic [63:0] m_mir = '0;
    logic        m_boot = 1'b1, m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0]  stk [$];

    always #5 clk = ~clk;

    microseq_ctrl_store #(.ADDR_W(8), .WORD_W(64), .COND_SEL_W(3), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .hold(hold), .map_addr(map_addr), .cond(cond),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .upc(upc), .ctrl_out(ctrl_out),
        .cond_taken(cond_taken), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    function automatic logic [63:0] mk(input logic [2:0] op, input logic inv, input logic [2:0] s,
                                       input logic [7:0] cr, input logic [48:0] ctrl);
        return {op, inv, s, cr, ctrl};
    endfunction

    // Reference sequencer: fields decoded from the word, stack kept as a queue
    always @(posedge clk) begin : model_b
        logic [7:0] n, inc, cr;
        logic [2:0] op;
        logic       t;
        op  = m_mir[63:61];
        cr  = m_mir[56:49];
        t   = cond[m_mir[59:57]] ^ m_mir[60];
        inc = m_upc + 8'd1;
        if (reset) begin
            m_upc = '0; m_mir = '0; m_boot = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
            stk.delete();
        end else if (m_boot) begin
            m_boot = 1'b0; m_upc = '0; m_mir = m_mem[0];
        end else if (!hold) begin
            case (op)
                3'd0: n = inc;
                3'd1: n = cr;
                3'd2: n = map_addr;
                3'd3: n = t ? cr : inc;
`ifdef MICROSEQ_STACK_EN
                3'd4: begin
                    n = cr;
                    if (stk.size() < 4) stk.push_back(inc);
                    else m_ovf = 1'b1;
                end
                3'd5: begin
                    if (stk.size() == 0) begin n = '0; m_unf = 1'b1; end
                    else n = stk.pop_back();
                end
`else
                3'd4: n = cr;
                3'd5: n = '0;
`endif
                3'd6: n = t ? inc : m_upc;
                default: n = '0;
            endcase
            m_upc = n;
            m_mir = m_mem[n];
        end
        if (ld_we) m_mem[ld_addr] = ld_data;
    end

    always @(negedge clk) if (chk_en) begin
        logic exp_ct;
        exp_ct = m_boot ? 1'b0 : cond[m_mir[59:57]] ^ m_mir[60];
        tests++;
        if (upc !== m_upc || ctrl_out !== m_mir[48:0] || cond_taken !== exp_ct ||
            stack_ovf !== m_ovf || stack_unf !== m_unf) begin
            fails++;
            $display("FAIL model t=%0t upc %h exp %h ctrl %h exp %h ct %b exp %b ovf %b exp %b unf %b exp %b",
                     $time, upc, m_upc, ctrl_out, m_mir[48:0], cond_taken, exp_ct,
                     stack_ovf, m_ovf, stack_unf, m_unf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [63:0] w);
        ld_we = 1'b1; ld_addr = a; ld_data = w;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic go(input logic [7:0] target);
        reset = 1'b1;
        map_addr = target;
        load(8'h00, mk(3'd2, 1'b0, 3'd0, 8'h00, 49'h0DD));
        reset = 1'b0;
        tick();
        tick();
        chk("go_upc", 64'(upc), 64'(target));
    endtask

    logic [7:0] stk_seq [$];

    initial begin
        for (int a = 0; a < 256; a++) load(8'(a), 64'h0);
        chk_en = 1'b1;

        load(8'h00, mk(3'd0, 1'b0, 3'd0, 8'h00, 49'h111));
        load(8'h01, mk(3'd1, 1'b0, 3'd0, 8'h10, 49'h222));
        load(8'h10, mk(3'd1, 1'b0, 3'd0, 8'h10, 49'h333));
        cond = 8'hFF;
        #1;
        chk("rst_upc", 64'(upc), 64'h0);
        chk("rst_ctrl", 64'(ctrl_out), 64'h0);
        chk("rst_ct", 64'(cond_taken), 64'h0);
        reset = 1'b0;
        tick(); chk("boot_upc", 64'(upc), 64'h0);  chk("boot_ctrl", 64'(ctrl_out), 64'h111);
        tick(); chk("incr_upc", 64'(upc), 64'h1);  chk("incr_ctrl", 64'(ctrl_out), 64'h222);
        tick(); chk("jump_upc", 64'(upc), 64'h10); chk("jump_ctrl", 64'(ctrl_out), 64'h333);

        load(8'h20, mk(3'd3, 1'b0, 3'd2, 8'h40, 49'h1));
        load(8'h40, mk(3'd1, 1'b0, 3'd0, 8'h40, 49'h2));
        load(8'h21, mk(3'd1, 1'b0, 3'd0, 8'h21, 49'h3));
        go(8'h20); cond = 8'h04; #1; chk("cbr_ct", 64'(cond_taken), 64'h1);
        tick(); chk("cbr_taken", 64'(upc), 64'h40);
        go(8'h20); cond = 8'h00; tick(); chk("cbr_fall", 64'(upc), 64'h21);
        load(8'h20, mk(3'd3, 1'b1, 3'd2, 8'h40, 49'h1));
        go(8'h20); cond = 8'h00; tick(); chk("cbr_inv", 64'(upc), 64'h40);

        load(8'h05, mk(3'd6, 1'b0, 3'd0, 8'h00, 49'h55));
        load(8'h06, mk(3'd1, 1'b0, 3'd0, 8'h06, 49'h66));
        cond = 8'h00; go(8'h05);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("wait_upc", 64'(upc), 64'h5); chk("wait_ctrl", 64'(ctrl_out), 64'h55);
        end
        cond = 8'h01; tick(); chk("wait_done", 64'(upc), 64'h6);
        go(8'h05); hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); chk("hold_upc", 64'(upc), 64'h5); chk("hold_ctrl", 64'(ctrl_out), 64'h55);
        end
        hold = 1'b0; tick(); chk("hold_rel", 64'(upc), 64'h6);

        for (int i = 0; i < 5; i++) begin
            load(8'(8'h50 + 2 * i), mk(3'd4, 1'b0, 3'd0, 8'(8'h52 + 2 * i), 49'(i)));
            load(8'(8'h51 + 2 * i), mk(3'd5, 1'b0, 3'd0, 8'h00, 49'(16 + i)));
        end
        load(8'h5A, mk(3'd5, 1'b0, 3'd0, 8'h00, 49'h5A));
`ifdef MICROSEQ_STACK_EN
        stk_seq = '{8'h52, 8'h54, 8'h56, 8'h58, 8'h5A, 8'h57, 8'h55, 8'h53, 8'h51, 8'h00};
`else
        stk_seq = '{8'h52, 8'h54, 8'h56, 8'h58, 8'h5A, 8'h00};
`endif
        go(8'h50);
        foreach (stk_seq[i]) begin
            tick(); chk("stack_upc", 64'(upc), 64'(stk_seq[i]));
            if (i == 3) chk("ovf_before", 64'(stack_ovf), 64'h0);
        end
`ifdef MICROSEQ_STACK_EN
        chk("ovf_set", 64'(stack_ovf), 64'h1);
        chk("unf_set", 64'(stack_unf), 64'h1);
`else
        chk("ovf_tied", 64'(stack_ovf), 64'h0);
        chk("unf_tied", 64'(stack_unf), 64'h0);
`endif

        load(8'h03, mk(3'd2, 1'b0, 3'd0, 8'h00, 49'h7));
        load(8'h80, mk(3'd1, 1'b0, 3'd0, 8'h80, 49'h8));
        go(8'h03); map_addr = 8'h80; tick(); chk("map_upc", 64'(upc), 64'h80);
        load(8'hFF, mk(3'd0, 1'b0, 3'd0, 8'h00, 49'h9));
        go(8'hFF); tick(); chk("wrap_upc", 64'(upc), 64'h0); chk("wrap_ctrl", 64'(ctrl_out), 64'h0DD);

        load(8'h60, mk(3'd1, 1'b0, 3'd0, 8'h61, 49'hA));
        load(8'h61, mk(3'd1, 1'b0, 3'd0, 8'h60, 49'hB));
        go(8'h60);
        load(8'h61, mk(3'd1, 1'b0, 3'd0, 8'h60, 49'hC));
        chk("rbw_upc", 64'(upc), 64'h61); chk("rbw_old", 64'(ctrl_out), 64'hB);
        tick(); chk("rbw_back", 64'(ctrl_out), 64'hA);
        tick(); chk("rbw_new", 64'(ctrl_out), 64'hC);

        cond = 8'h00; go(8'h05); tick(); chk("rwait_upc", 64'(upc), 64'h5);
        reset = 1'b1; tick();
        chk("rwait_rst_upc", 64'(upc), 64'h0); chk("rwait_rst_ctrl", 64'(ctrl_out), 64'h0);
        chk("rwait_rst_ct", 64'(cond_taken), 64'h0);
        reset = 1'b0; tick();
        chk("rwait_boot_upc", 64'(upc), 64'h0); chk("rwait_boot_ctrl", 64'(ctrl_out), 64'h0DD);

        reset = 1'b1;
        for (int a = 0; a < 256; a++) load(8'(a), {$urandom, $urandom});
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cond     = 8'($urandom);
            hold     = $urandom_range(0, 3) == 0;
            map_addr = 8'($urandom);
            ld_we    = $urandom_range(0, 7) == 0;
            ld_addr  = 8'($urandom);
            ld_data  = {$urandom, $urandom};
            reset    = $urandom_range(0, 99) == 0;
            tick();
        end
        ld_we = 1'b0; reset = 1'b0; hold = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
